instr_fetch_issue: RTL
======================

// Module: instr_fetch_issue
// PURPOSE
//   Instruction fetch/issue stage: drives the control decoder's opcode/function_val inputs.
//   Fetches 32-bit words from instruction memory over a req/ack handshake and holds them in an instruction register.
//   Splits the word into fields and presents them for one DECODE window.
//   Computes next PC from the decoder's pc_sel plus branch/jump targets.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   HALT_OP     6'b111111      opcode that stops fetching
//   ACK_TIMEOUT 16             max FETCH cycles without imem_ack before fetch_err
// PORTS
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   imem_addr     out  32  fetch address (= pc)
//   imem_req      out  1   fetch request
//   imem_ack      in   1   memory ack; imem_rdata valid this cycle
//   imem_rdata    in   32  instruction word
//   pc_sel        in   2   from decoder: 00 seq, 01 branch, 10 jump, 11 jump-reg
//   br_taken      in   1   branch condition result
//   br_target     in   32  branch target address
//   reg_target    in   32  register jump target
//   stall         in   1   hold current instruction in DECODE
//   opcode        out  6   IR[31:26]
//   function_val  out  6   IR[5:0]
//   rs, rt, rd    out  5   IR[25:21], IR[20:16], IR[15:11]
//   shamt         out  5   IR[10:6]
//   imm           out  16  IR[15:0]
//   jidx          out  26  IR[25:0]
//   instr_valid   out  1   IR fields valid; decoder outputs meaningful
//   pc, pc_plus4  out  32  address of IR; pc+4 (mod 2^32)
//   halted        out  1   HALT state reached
//   fetch_err     out  1   sticky: ack timeout occurred
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE, pc=RESET_PC, IR=0, to_cnt=0, fetch_err=0.
//     Hence imem_req=0, instr_valid=0, halted=0, and all field outputs are 0.
//   States: IDLE, FETCH, DECODE, HALT (registered). Outputs decode from state and regs; no combinational input->output paths.
//     imem_req = (state==FETCH); instr_valid = (state==DECODE); halted = (state==HALT).
//   IDLE: first rising edge after rst_n deasserts -> FETCH.
//   FETCH:
//     imem_addr=pc.
//     imem_ack=1 -> IR<=imem_rdata, to_cnt<=0, -> DECODE.
//     Otherwise to_cnt++. If to_cnt reaches ACK_TIMEOUT-1 without ack: fetch_err<=1, -> HALT.
//   DECODE:
//     stall=1 -> hold: IR, pc and outputs unchanged.
//     stall=0 and opcode==HALT_OP -> HALT; pc unchanged.
//     Otherwise pc<=next_pc, -> FETCH.
//   next_pc (sampled only on the DECODE exit edge):
//     00 -> pc+4
//     01 -> br_taken ? br_target : pc+4
//     10 -> {pc_plus4[31:28], jidx, 2'b00}
//     11 -> reg_target
//   HALT: terminal; only reset exits. imem_req=0.
//   Minimum issue interval: 2 cycles per instruction (1 FETCH with immediate ack + 1 DECODE).
//   Boundary conditions:
//     pc wraps 32'hFFFF_FFFC -> 0 with no flag.
//     imem_ack outside FETCH is ignored.
//     stall in FETCH is ignored.
//     Reset mid-FETCH drops the request immediately.
// TESTING
//   1. Reset, immediate ack, words 0x00000020, 0x00000022, pc_sel=00
//      -> imem_addr 0, 4, 8; instr_valid every 2nd cycle; function_val 32 then 34.
//   2. Word opcode=4 (0x1000_0003) at pc=8, pc_sel=01:
//      br_taken=1, br_target=0x40 -> next fetch at 0x40; br_taken=0 -> next fetch at 0xC.
//   3. Word 0x0800_0010 at pc=0x1000_0000, pc_sel=10 -> next imem_addr=0x1000_0040.
//   4. stall=1 for 3 DECODE cycles -> instr_valid held 4 cycles, IR/pc unchanged, imem_req=0 throughout.
//   5. Word 0xFC00_0000 (opcode HALT_OP) -> halted=1 one cycle after DECODE; imem_req stays 0; pc unchanged.
//   6. Withhold ack for 16 cycles -> fetch_err=1, halted=1.
//      Then rst_n pulse -> pc=0, fetch_err=0, fetch resumes at 0.

Source files
------------

// File: rtl/instr_fetch_issue.sv
// Fetch/issue stage: fetches a word over req/ack, holds it in IR for one DECODE window, then steps the PC.
// Latency: 1 FETCH cycle (immediate ack) + 1 DECODE cycle per instruction; stall holds DECODE and no request is issued.
module instr_fetch_issue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP     = 6'b111111,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] reg_target_i,
  input  logic        stall_i,
  output logic [5:0]  opcode_o,
  output logic [5:0]  function_val_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [15:0] imm_o,
  output logic [25:0] jidx_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        halted_o,
  output logic        fetch_err_o
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic [31:0]     pc_plus4;
  logic [31:0]     next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_sel_i)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = br_taken_i ? br_target_i : pc_plus4;
      2'b10: next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      2'b11: next_pc = reg_target_i;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack_i) begin
          ir_d     = imem_rdata_i;
          to_cnt_d = '0;
          state_d  = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_DECODE: begin
        // PC only advances on the DECODE exit edge, and not for a halt opcode
        if (!stall_i) begin
          if (ir_q[31:26] == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign imem_addr_o    = pc_q;
  assign imem_req_o     = (state_q == S_FETCH);
  assign instr_valid_o  = (state_q == S_DECODE);
  assign halted_o       = (state_q == S_HALT);
  assign fetch_err_o    = err_q;
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4;
  assign opcode_o       = ir_q[31:26];
  assign function_val_o = ir_q[5:0];
  assign rs_o           = ir_q[25:21];
  assign rt_o           = ir_q[20:16];
  assign rd_o           = ir_q[15:11];
  assign shamt_o        = ir_q[10:6];
  assign imm_o          = ir_q[15:0];
  assign jidx_o         = ir_q[25:0];

endmodule
